// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared state encoding and default widths for the RAM port-A
//             arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    // Arbiter ownership state
    typedef enum logic {
        S_CORE      = 1'b0,
        S_AUX_BURST = 1'b1
    } arb_state_t;

    // Default RAM geometry
    localparam int ARB_ADDR_W = 15;
    localparam int ARB_DATA_W = 16;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_counter
//  Brief    : Saturating up-counter with synchronous clear. hit is high while
//             the count sits at LIMIT.
//  Revision : 1.0  initial release
// ============================================================================
module arb_starve_counter #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    // Count waiting cycles, clear wins over increment, stop at LIMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == CNT_W'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_arbiter
//  Brief    : Shares RAM port A between the CPU core (fixed priority) and an
//             auxiliary master protected by a starvation counter and allowed
//             short locked bursts.
//  Options  : ARB_STATS_EN adds grant / conflict statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module ram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    input  logic              aux_lock,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       core_grants,
    output logic [15:0]       aux_grants,
    output logic [15:0]       conflicts
`endif
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);

    arb_state_t         state;
    arb_state_t         next_state;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_next;
    logic               burst_active;
    logic               starve_hit;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (aux_req & ~aux_gnt),
        .clr   (aux_gnt),
        .hit   (starve_hit)
    );

    // State and burst-length registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_CORE;
            burst_cnt <= '0;
        end else begin
            state     <= next_state;
            burst_cnt <= burst_next;
        end
    end

    // Grant decision and next state. Once a burst has used MAX_BURST grants
    // the cycle is arbitrated exactly like S_CORE, so a waiting core takes
    // the port immediately instead of losing a cycle to the release.
    always_comb begin
        core_gnt     = 1'b0;
        aux_gnt      = 1'b0;
        next_state   = S_CORE;
        burst_next   = '0;
        burst_active = (state == S_AUX_BURST) && (burst_cnt != BURST_W'(MAX_BURST));
        if (burst_active) begin
            aux_gnt = aux_req;
            if (aux_req && aux_lock) begin
                next_state = S_AUX_BURST;
                burst_next = burst_cnt + 1'b1;
            end
        end else begin
            // A starved aux only overrides the core while it is still asking
            if (core_req && !(starve_hit && aux_req)) begin
                core_gnt = 1'b1;
            end else if (aux_req) begin
                aux_gnt = 1'b1;
            end
            if (aux_gnt && aux_lock) begin
                next_state = S_AUX_BURST;
                burst_next = BURST_W'(1);
            end
        end
    end

    // Port-A mux: core values are presented whenever aux is not granted
    always_comb begin
        ram_we   = core_gnt & core_we;
        ram_addr = core_addr;
        ram_din  = core_wdata;
        if (aux_gnt) begin
            ram_we   = aux_we;
            ram_addr = aux_addr;
            ram_din  = aux_wdata;
        end
    end

    // Read-return pulses one cycle after a granted read
    always_ff @(posedge clk) begin
        if (reset) begin
            core_rvalid <= 1'b0;
            aux_rvalid  <= 1'b0;
        end else begin
            core_rvalid <= core_gnt & ~core_we;
            aux_rvalid  <= aux_gnt & ~aux_we;
        end
    end

    assign core_rdata = ram_dout;
    assign aux_rdata  = ram_dout;

`ifdef ARB_STATS_EN
    // Free-running wrap-around statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            core_grants <= '0;
            aux_grants  <= '0;
            conflicts   <= '0;
        end else begin
            if (core_gnt)            core_grants <= core_grants + 16'd1;
            if (aux_gnt)             aux_grants  <= aux_grants + 16'd1;
            if (core_req && aux_req) conflicts   <= conflicts + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_port_arbiter
//  Brief    : Randomized self-checking bench for ram_port_arbiter with a
//             behavioural arbitration model and a read-return scoreboard.
//  Options  : ARB_STATS_EN also checks the statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    localparam int ADDR_W       = 15;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 8;
    localparam int MAX_BURST    = 16;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              core_req, core_we, core_gnt, core_rvalid;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata, core_rdata;
    logic              aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata, aux_rdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;
`ifdef ARB_STATS_EN
    logic [15:0]       core_grants, aux_grants, conflicts;
`endif

    ram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_lock(aux_lock), .aux_gnt(aux_gnt),
        .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
`ifdef ARB_STATS_EN
        , .core_grants(core_grants), .aux_grants(aux_grants), .conflicts(conflicts)
`endif
    );

    always #5 clk = ~clk;

    // RAM port A: one-cycle read latency
    logic [DATA_W-1:0] ram_mem [0:32767];
    logic [DATA_W-1:0] ref_mem [0:32767];
    always @(posedge clk) begin
        if (ram_we === 1'b1) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_word(input int a);
        return DATA_W'((a * 40503) ^ 32'h5A5A);
    endfunction

    // Requester intents (held until the model says granted)
    logic              c_pend = 0, c_we = 0, a_pend = 0, a_we = 0, a_lock = 0;
    logic [ADDR_W-1:0] c_addr = 0, a_addr = 0;
    logic [DATA_W-1:0] c_wdata = 0, a_wdata = 0;

    // Reference model: consecutive aux-waiting cycles, and the locked hold
    int waited = 0;
    bit aux_holds = 0;
    int held = 0;
    int n_core = 0, n_aux = 0, n_conf = 0;

    rd_t core_q[$];
    rd_t aux_q[$];

    logic dut_cg, dut_ag;

    task automatic new_core(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        c_pend = 1; c_we = we; c_addr = addr; c_wdata = wd;
    endtask

    task automatic new_aux(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd, input logic lk);
        a_pend = 1; a_we = we; a_addr = addr; a_wdata = wd; a_lock = lk;
    endtask

    task automatic apply_inputs();
        core_req = c_pend; core_we = c_we; core_addr = c_addr; core_wdata = c_wdata;
        aux_req = a_pend; aux_we = a_we; aux_addr = a_addr; aux_wdata = a_wdata; aux_lock = a_lock;
    endtask

    // One arbitration cycle: drive, predict, compare, advance the model
    task automatic step();
        bit ec, ea, locked_phase;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
        rd_t r;
        apply_inputs();
        @(negedge clk); #1;
        locked_phase = aux_holds && (held < MAX_BURST);
        if (locked_phase) begin
            ec = 0;
            ea = a_pend;
        end else begin
            ec = c_pend && !(a_pend && waited >= STARVE_LIMIT);
            ea = a_pend && !ec;
        end
        e_we   = ec ? c_we : (ea ? a_we : 1'b0);
        e_addr = ea ? a_addr : c_addr;
        e_din  = ea ? a_wdata : c_wdata;
        dut_cg = core_gnt;
        dut_ag = aux_gnt;
        check("core_gnt", core_gnt, ec);
        check("aux_gnt", aux_gnt, ea);
        check("ram_we", ram_we, e_we);
        check("ram_addr", ram_addr, e_addr);
        check("ram_din", ram_din, e_din);
        if (ec) begin
            n_core++;
            if (c_we) ref_mem[c_addr] = c_wdata;
            else begin r.data = ref_mem[c_addr]; r.due = cyc + 1; core_q.push_back(r); end
        end
        if (ea) begin
            n_aux++;
            if (a_we) ref_mem[a_addr] = a_wdata;
            else begin r.data = ref_mem[a_addr]; r.due = cyc + 1; aux_q.push_back(r); end
        end
        if (c_pend && a_pend) n_conf++;
        if (ea) waited = 0;
        else if (a_pend && waited < STARVE_LIMIT) waited++;
        if (locked_phase) begin
            if (ea) held++;
            aux_holds = ea && a_lock;
        end else if (ea && a_lock) begin
            aux_holds = 1; held = 1;
        end else begin
            aux_holds = 0;
        end
        @(posedge clk); #1;
        if (ec) c_pend = 0;
        if (ea) a_pend = 0;
    endtask

    task automatic gen(input int pc, input int pa, input int plock);
        if (!c_pend && $urandom_range(99) < pc)
            new_core(1'($urandom_range(1)), ADDR_W'($urandom_range(31)), DATA_W'($urandom));
        if (!a_pend && $urandom_range(99) < pa)
            new_aux(1'($urandom_range(1)), ADDR_W'($urandom_range(31)), DATA_W'($urandom),
                    1'($urandom_range(99) < plock));
    endtask

    // Read-return monitor: pops the scoreboard when a return is due
    always @(negedge clk) begin
        rd_t r;
        if (core_q.size() > 0 && core_q[0].due == cyc) begin
            r = core_q.pop_front();
            check("core_rvalid", core_rvalid, 1);
            check("core_rdata", core_rdata, r.data);
        end else if (core_rvalid === 1'b1) begin
            check("core_rvalid_spurious", core_rvalid, 0);
        end
        if (aux_q.size() > 0 && aux_q[0].due == cyc) begin
            r = aux_q.pop_front();
            check("aux_rvalid", aux_rvalid, 1);
            check("aux_rdata", aux_rdata, r.data);
        end else if (aux_rvalid === 1'b1) begin
            check("aux_rvalid_spurious", aux_rvalid, 0);
        end
    end

    initial begin
        int idx, agc, aux_done, sent;
        bit found, seen, core_started;
        int pc[4]    = '{60, 90, 30, 50};
        int pa[4]    = '{60, 50, 90, 50};
        int plock[4] = '{30, 10, 80, 50};

        for (int i = 0; i < 32768; i++) begin
            ram_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        reset = 1;
        apply_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        check("reset_core_rvalid", core_rvalid, 0);
        check("reset_aux_rvalid", aux_rvalid, 0);

        // Core read of 0x0010
        new_core(0, 15'h0010, 16'h0);
        step();
        step();

        // Core write then aux read of the same word
        new_core(1, 15'h0005, 16'h1234);
        step();
        new_aux(0, 15'h0005, 16'h0, 0);
        step();
        step();

        // Starvation: core requests every cycle, aux waits
        new_aux(0, 15'h0003, 16'h0, 0);
        idx = 0; found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            if (!c_pend) new_core(0, ADDR_W'($urandom_range(31)), 16'h0);
            step();
            if (dut_ag) begin found = 1; idx = k; end
        end
        check("starve_grant_cycle", idx, 9);
        if (!c_pend) new_core(0, 15'h0001, 16'h0);
        step();
        check("core_regain", dut_cg, 1);
        step();

        // Locked aux burst of 20 writes; core starts asking after the first
        agc = 0; aux_done = 0; sent = 0; seen = 0; core_started = 0;
        for (int k = 0; k < 80 && aux_done < 20; k++) begin
            if (!a_pend && sent < 20) begin
                new_aux(1, ADDR_W'(32'h100 + sent), DATA_W'($urandom), 1);
                sent++;
            end
            if (k >= 1 && !core_started) begin
                new_core(0, 15'h0007, 16'h0);
                core_started = 1;
            end
            step();
            if (dut_ag) aux_done++;
            if (dut_ag && !seen) agc++;
            if (dut_cg) seen = 1;
        end
        check("burst_len", agc, 16);
        check("burst_total", aux_done, 20);
        step();

        // Reset in the middle of a locked burst with a read in flight
        for (int k = 0; k < 3; k++) begin
            if (!a_pend) new_aux(0, ADDR_W'($urandom_range(31)), 16'h0, 1);
            step();
        end
        new_aux(0, 15'h0009, 16'h0, 1);
        apply_inputs();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        c_pend = 0; a_pend = 0;
        waited = 0; aux_holds = 0; held = 0;
        n_core = 0; n_aux = 0; n_conf = 0;
        check("midburst_rst_aux_rvalid", aux_rvalid, 0);
        check("midburst_rst_core_rvalid", core_rvalid, 0);
        new_core(0, 15'h0002, 16'h0);
        new_aux(0, 15'h0004, 16'h0, 1);
        step();
        check("post_reset_core_gnt", dut_cg, 1);

        // Randomized traffic in several mixes
        for (int p = 0; p < 4; p++) begin
            repeat (500) begin
                gen(pc[p], pa[p], plock[p]);
                step();
            end
        end
        for (int k = 0; k < 40 && (c_pend || a_pend); k++) step();
        c_pend = 0; a_pend = 0;
        step();
        step();

`ifdef ARB_STATS_EN
        check("stat_core_grants", core_grants, n_core & 16'hFFFF);
        check("stat_aux_grants", aux_grants, n_aux & 16'hFFFF);
        check("stat_conflicts", conflicts, n_conf & 16'hFFFF);
`endif
        check("core_q_drained", core_q.size(), 0);
        check("aux_q_drained", aux_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single read/write port (port A) of the frame/data RAM between two requesters: the CPU core and an auxiliary master such as a fill/blit engine or a loader.
- Sits between the requesters and the memory dispatcher/RAM port-A address, data and write-enable inputs. The VGA read port is untouched.
- The core has fixed priority. The aux master is protected from starvation by a wait counter and may hold the port for short locked bursts.

Parameters:
- ADDR_W, 15, RAM word-address width
- DATA_W, 16, RAM data width
- STARVE_LIMIT, 8, consecutive aux-waiting cycles before aux is forced a grant
- MAX_BURST, 16, maximum cycles aux may hold the port under aux_lock

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- core_req  in  1  core requests port this cycle
- core_we  in  1  core write (1) / read (0)
- core_addr  in  ADDR_W  core word address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  core access issued this cycle (combinational)
- core_rvalid  out  1  core read data valid on core_rdata
- core_rdata  out  DATA_W  read data to core
- aux_req, aux_we, aux_addr, aux_wdata  in  1/1/ADDR_W/DATA_W  same meanings for the aux master
- aux_lock  in  1  aux requests to keep the port after its grant
- aux_gnt, aux_rvalid, aux_rdata  out  1/1/DATA_W  same meanings for the aux master
- ram_we  out  1  to RAM port A write enable
- ram_addr  out  ADDR_W  to RAM port A address
- ram_din  out  DATA_W  to RAM port A write data
- ram_dout  in  DATA_W  from RAM port A; valid 1 cycle after the address is applied

Behaviour:
- Clock and reset: clk is the only clock. reset is synchronous, active-high.
- Reset values: state=S_CORE, starve_cnt=0, burst_cnt=0, core_rvalid=0, aux_rvalid=0.
- Handshake:
  - A requester holds req and its operands stable until it sees gnt=1 in the same cycle.
  - The access is issued in that cycle.
  - At most one gnt is high per cycle.
- State S_CORE:
  - If core_req and the starvation condition is not met: grant core.
  - Otherwise, if aux_req: grant aux.
  - If aux is granted with aux_lock=1, go to S_AUX_BURST with burst_cnt=1.
- State S_AUX_BURST:
  - Aux is granted whenever aux_req=1; core_gnt=0.
  - Return to S_CORE when aux_lock=0, or when burst_cnt==MAX_BURST (forced release), or when aux_req=0.
  - burst_cnt increments on each aux grant.
- Starvation:
  - starve_cnt increments each cycle that aux_req=1 and aux_gnt=0, and saturates at STARVE_LIMIT.
  - When starve_cnt==STARVE_LIMIT, aux wins the next cycle even if core_req=1.
  - starve_cnt clears on any aux grant.
- RAM outputs:
  - ram_addr, ram_din and ram_we are muxed combinationally from the granted requester.
  - ram_we=0 when there is no grant; ram_addr and ram_din then hold the core values.
- Read return:
  - core_rvalid is a 1-cycle registered pulse, 1 cycle after a granted core read.
  - aux_rvalid behaves the same for aux reads.
  - core_rdata = aux_rdata = ram_dout (shared wires).
  - Writes produce no rvalid.
- Back-to-back reads by either master at full rate give one rvalid per cycle, in order.
- Simultaneous core_req and aux_req with starve_cnt<STARVE_LIMIT: core wins.
- Reset asserted mid-burst: state returns to S_CORE; any rvalid due that cycle is suppressed.
- The arbiter does no address translation; memory-mapped I/O decode stays in the dispatcher.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined:
  - Adds output ports core_grants[15:0], aux_grants[15:0] and conflicts[15:0].
  - All three are free-running counters that wrap at 65535→0 and clear on reset.
  - conflicts increments when core_req and aux_req are both 1 in a cycle.
- When undefined: the ports and counters are absent and arbitration is identical.

Decomposition:
- Shared package arb_pkg: state encoding (S_CORE=1'b0, S_AUX_BURST=1'b1) and the default ADDR_W/DATA_W constants.
- One sub-module: arb_starve_counter (saturating up-counter with clear, parameter LIMIT, output hit).
- All other logic lives in ram_port_arbiter.

Test Plan:
- Core only: read addr 0x0010 in cycle N → core_gnt=1 in N, ram_addr=0x0010, core_rvalid=1 in N+1 with the RAM word.
- Both request, core continuously with STARVE_LIMIT=8 → aux_gnt=1 exactly on the 9th cycle of aux waiting, then core regains the port.
- Aux burst: aux_lock=1, 20 consecutive writes to 0x0100..0x0113 with MAX_BURST=16 → 16 aux grants, release and core grant, then the remaining 4 writes, with core_gnt=0 throughout the burst.
- Interleaved: core write 0x1234 to 0x0005, then aux read 0x0005 the next cycle → aux_rdata=0x1234 with aux_rvalid one cycle after aux_gnt.
- Reset asserted during S_AUX_BURST with a pending read → next cycle aux_rvalid=0, state S_CORE, core granted immediately.
- With ARB_STATS_EN, 5 simultaneous-request cycles → conflicts=5 and the grant counters match the number of gnt pulses.
